// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO read port (1- or 2-cycle read latency) into a
// valid/ready stream. A small circular skid buffer absorbs the read latency so
// the stream can sustain one word per cycle.
// Optional word counter: define FIFO_RD_STREAM_WORD_CNT_EN.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  drain_en,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_oce,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy
`ifdef FIFO_RD_STREAM_WORD_CNT_EN
  ,
  input  logic                  word_cnt_clr,
  output logic [31:0]           word_cnt
`endif
);

  // Occupancy sums need room for count + inflight without wrapping.
  localparam int SW = $clog2(BUF_DEPTH + RD_LATENCY) + 1;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [SW-1:0]         r_count, r_inflight;
  logic [SW-1:0]         w_count_nxt, w_infl_nxt, w_sum;
  logic [RD_LATENCY-1:0] r_issue;
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
  logic                  r_busy;
  logic                  w_pop, w_ret, w_rd_en;

  assign w_pop = m_valid & m_ready;
  // Oldest issue flag leaving the tracker marks returning FIFO data.
  assign w_ret = r_issue[RD_LATENCY-1];

  // Only issue when the word is guaranteed a buffer slot on return.
  assign w_sum   = r_count + r_inflight - SW'(w_pop);
  assign w_rd_en = drain_en & ~fifo_rd_empty & ~rd_rst & (w_sum < SW'(BUF_DEPTH));

  assign fifo_rd_en  = w_rd_en;
  assign fifo_rd_oce = 1'b1;
  assign m_valid     = (r_count != '0);
  assign m_data      = r_buf[r_rptr];
  assign busy        = r_busy;

  assign w_count_nxt = r_count + SW'(w_ret) - SW'(w_pop);
  assign w_infl_nxt  = r_inflight + SW'(w_rd_en) - SW'(w_ret);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy, read tracking, pointers and the registered busy flag.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_count    <= '0;
      r_inflight <= '0;
      r_issue    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_inflight <= w_infl_nxt;
      r_issue    <= (r_issue << 1) | RD_LATENCY'(w_rd_en);
      if (w_ret) r_wptr <= ptr_inc(r_wptr);
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_busy     <= (w_count_nxt != '0) | (w_infl_nxt != '0);
    end
  end

  // Skid buffer storage; returning data lands at the write pointer.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_buf[i] <= '0;
    end else if (w_ret) begin
      r_buf[r_wptr] <= fifo_rd_data;
    end
  end

  // A return into a full buffer means the issue rule is broken.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    w_ret |-> (r_count < SW'(BUF_DEPTH)));

`ifdef FIFO_RD_STREAM_WORD_CNT_EN
  logic [31:0] r_word_cnt;

  // Popped-word counter; clear wins over increment, wraps naturally.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)            r_word_cnt <= '0;
    else if (word_cnt_clr) r_word_cnt <= '0;
    else if (w_pop)        r_word_cnt <= r_word_cnt + 32'd1;
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: one instance with RD_LATENCY=1 and one with
// RD_LATENCY=2, each fed by its own FIFO read-port model, sharing stimulus.
module tb_fifo_rd_stream;

  logic        rd_clk = 1'b0;
  logic        rd_rst = 1'b1;
  logic        drain_en = 1'b0;
  logic        m_ready = 1'b0;

  logic        rd_en0, oce0, valid0, busy0, empty0;
  logic        rd_en1, oce1, valid1, busy1, empty1;
  logic [31:0] rdata0, mdata0, rdata1, mdata1, p1;

  logic [31:0] mem0 [0:511];
  logic [31:0] mem1 [0:511];
  int          wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
  logic [31:0] exp0 [$];
  logic [31:0] exp1 [$];

  int tests = 0, fails = 0;
  int pops0 = 0, pops1 = 0, rdens0 = 0, rdens1 = 0;
  logic        st0 = 1'b0, st1 = 1'b0;
  logic [31:0] sd0, sd1;

  always #5 rd_clk = ~rd_clk;

  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(1)) u_l1 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .drain_en(drain_en),
    .fifo_rd_en(rd_en0), .fifo_rd_oce(oce0), .fifo_rd_data(rdata0),
    .fifo_rd_empty(empty0), .m_valid(valid0), .m_ready(m_ready),
    .m_data(mdata0), .busy(busy0));

  fifo_rd_stream #(.DATA_WIDTH(32), .RD_LATENCY(2)) u_l2 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .drain_en(drain_en),
    .fifo_rd_en(rd_en1), .fifo_rd_oce(oce1), .fifo_rd_data(rdata1),
    .fifo_rd_empty(empty1), .m_valid(valid1), .m_ready(m_ready),
    .m_data(mdata1), .busy(busy1));

  // FIFO model, 1-cycle read latency; reset discards stored words.
  always @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rp0 <= wp0; rdata0 <= '0;
    end else if (rd_en0) begin
      rdata0 <= mem0[rp0]; rp0 <= rp0 + 1;
    end
  end

  // FIFO model, 2-cycle read latency (output register behind oce).
  always @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rp1 <= wp1; p1 <= '0; rdata1 <= '0;
    end else begin
      if (rd_en1) begin p1 <= mem1[rp1]; rp1 <= rp1 + 1; end
      if (oce1) rdata1 <= p1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem0[wp0] = w; wp0++;
    mem1[wp1] = w; wp1++;
    exp0.push_back(w);
    exp1.push_back(w);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  // Monitor for the latency-1 instance: scoreboard, stall stability, bounds.
  always @(negedge rd_clk) begin
    chk("l1_rden_while_empty", 32'(rd_en0 & empty0), 0);
    if (rd_en0) rdens0++;
    if (rd_rst) st0 = 1'b0;
    else begin
      if (st0) begin
        chk("l1_stall_valid", 32'(valid0), 1);
        chk("l1_stall_data", mdata0, sd0);
      end
      chk("l1_count_bound", 32'(u_l1.r_count <= 2), 1);
      if (valid0 & m_ready) begin
        pops0++;
        chk("l1_sb_has_entry", 32'(exp0.size() != 0), 1);
        if (exp0.size() != 0) chk("l1_sb_data", mdata0, exp0.pop_front());
      end
      st0 = valid0 & ~m_ready;
      sd0 = mdata0;
    end
  end

  // Monitor for the latency-2 instance.
  always @(negedge rd_clk) begin
    chk("l2_rden_while_empty", 32'(rd_en1 & empty1), 0);
    if (rd_en1) rdens1++;
    if (rd_rst) st1 = 1'b0;
    else begin
      if (st1) begin
        chk("l2_stall_valid", 32'(valid1), 1);
        chk("l2_stall_data", mdata1, sd1);
      end
      chk("l2_count_bound", 32'(u_l2.r_count <= 3), 1);
      if (valid1 & m_ready) begin
        pops1++;
        chk("l2_sb_has_entry", 32'(exp1.size() != 0), 1);
        if (exp1.size() != 0) chk("l2_sb_data", mdata1, exp1.pop_front());
      end
      st1 = valid1 & ~m_ready;
      sd1 = mdata1;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    fails++;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int b0, b1, r0, r1, f0, f1, l0, l1, n0, n1;

    // Reset values while held in reset and just after release.
    step(3);
    chk("rst_rden0", 32'(rd_en0), 0);  chk("rst_rden1", 32'(rd_en1), 0);
    chk("rst_oce0", 32'(oce0), 1);     chk("rst_oce1", 32'(oce1), 1);
    chk("rst_valid0", 32'(valid0), 0); chk("rst_valid1", 32'(valid1), 0);
    chk("rst_data0", mdata0, 0);       chk("rst_data1", mdata1, 0);
    chk("rst_busy0", 32'(busy0), 0);   chk("rst_busy1", 32'(busy1), 0);
    rd_rst = 1'b0;
    step(2);
    chk("post_rst_valid0", 32'(valid0), 0);
    chk("post_rst_busy1", 32'(busy1), 0);

    // Basic drain: first word at rd_en cycle + RD_LATENCY + 1.
    m_ready = 1'b1;
    push(32'h11); push(32'h22); push(32'h33);
    drain_en = 1'b1;
    @(negedge rd_clk);
    chk("bd_rden0", 32'(rd_en0), 1); chk("bd_rden1", 32'(rd_en1), 1);
    @(negedge rd_clk);
    chk("bd_n1_valid0", 32'(valid0), 0); chk("bd_n1_valid1", 32'(valid1), 0);
    @(negedge rd_clk);
    chk("bd_n2_valid0", 32'(valid0), 1); chk("bd_n2_data0", mdata0, 32'h11);
    chk("bd_n2_busy0", 32'(busy0), 1);   chk("bd_n2_valid1", 32'(valid1), 0);
    @(negedge rd_clk);
    chk("bd_n3_data0", mdata0, 32'h22);
    chk("bd_n3_valid1", 32'(valid1), 1); chk("bd_n3_data1", mdata1, 32'h11);
    @(negedge rd_clk);
    chk("bd_n4_data0", mdata0, 32'h33);  chk("bd_n4_data1", mdata1, 32'h22);
    @(negedge rd_clk);
    chk("bd_n5_valid0", 32'(valid0), 0); chk("bd_n5_busy0", 32'(busy0), 0);
    chk("bd_n5_data1", mdata1, 32'h33);
    @(negedge rd_clk);
    chk("bd_n6_valid1", 32'(valid1), 0); chk("bd_n6_busy1", 32'(busy1), 0);
    step(2);

    // Full throughput: 64 words with no gaps after the first.
    for (int i = 0; i < 64; i++) push(32'h1000 + 32'(i));
    f0 = -1; f1 = -1; l0 = 0; l1 = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge rd_clk);
      if (valid0) begin if (f0 < 0) f0 = c; l0 = c; n0++; end
      if (valid1) begin if (f1 < 0) f1 = c; l1 = c; n1++; end
    end
    chk("tp_count0", n0, 64);         chk("tp_count1", n1, 64);
    chk("tp_span0", l0 - f0 + 1, 64); chk("tp_span1", l1 - f1 + 1, 64);
    step(1);

    // Backpressure: random 50% ready over 200 words.
    for (int i = 0; i < 200; i++) push(32'h2000 + 32'(i));
    for (int c = 0; c < 3000 && (exp0.size() != 0 || exp1.size() != 0); c++) begin
      @(posedge rd_clk); #1;
      m_ready = 1'($urandom_range(0, 1));
    end
    m_ready = 1'b1;
    chk("bp_drained0", exp0.size(), 0); chk("bp_drained1", exp1.size(), 0);
    step(4);
    chk("bp_busy0", 32'(busy0), 0);     chk("bp_busy1", 32'(busy1), 0);

    // Empty boundary: one word, gap of 5 cycles, one more word.
    b0 = pops0; b1 = pops1; r0 = rdens0; r1 = rdens1;
    push(32'h3001);
    step(5);
    push(32'h3002);
    step(12);
    chk("eb_pops0", pops0 - b0, 2);   chk("eb_pops1", pops1 - b1, 2);
    chk("eb_rdens0", rdens0 - r0, 2); chk("eb_rdens1", rdens1 - r1, 2);

    // drain_en pause with two reads in flight.
    drain_en = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h4001 + 32'(i));
    step(2);
    b0 = pops0; b1 = pops1; r0 = rdens0; r1 = rdens1;
    drain_en = 1'b1;
    step(2);
    drain_en = 1'b0;
    step(10);
    chk("dp_pops0", pops0 - b0, 2);   chk("dp_pops1", pops1 - b1, 2);
    chk("dp_rdens0", rdens0 - r0, 2); chk("dp_rdens1", rdens1 - r1, 2);
    chk("dp_busy0", 32'(busy0), 0);   chk("dp_busy1", 32'(busy1), 0);
    drain_en = 1'b1;
    step(12);
    chk("dp_resume0", pops0 - b0, 5); chk("dp_resume1", pops1 - b1, 5);

    // Reset mid-stream with a full skid buffer.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h5001 + 32'(i));
    step(8);
    chk("rm_valid0", 32'(valid0), 1);
    chk("rm_count0", 32'(u_l1.r_count), 2);
    chk("rm_count1", 32'(u_l2.r_count), 3);
    #2;
    rd_rst = 1'b1;
    #1;
    chk("rm_async_valid0", 32'(valid0), 0); chk("rm_async_valid1", 32'(valid1), 0);
    chk("rm_async_busy0", 32'(busy0), 0);   chk("rm_async_rden0", 32'(rd_en0), 0);
    exp0.delete(); exp1.delete();
    step(2);
    rd_rst = 1'b0;
    m_ready = 1'b1;
    b0 = pops0; b1 = pops1;
    push(32'h6001); push(32'h6002);
    step(12);
    chk("rm_pops0", pops0 - b0, 2);      chk("rm_pops1", pops1 - b1, 2);
    chk("rm_drained0", exp0.size(), 0);  chk("rm_drained1", exp1.size(), 0);
    chk("end_busy0", 32'(busy0), 0);     chk("end_busy1", 32'(busy1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the UART FIFO path. It pulls words from the read port of the parameterized FIFO (`rd_en`/`rd_data`/`rd_empty`, 1- or 2-cycle read latency) and presents them as a valid/ready stream to the downstream consumer, such as the UART transmitter. An internal skid buffer absorbs the FIFO read latency, so the stream sustains one word per cycle without dropping or duplicating data.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of FIFO read data and stream data.
- `RD_LATENCY`, 1, FIFO read latency in cycles: 1 without the FIFO output register, 2 with it. Legal values: 1 or 2.
- `BUF_DEPTH`, `RD_LATENCY+1`, skid buffer entries. Must be ≥ `RD_LATENCY+1`.

Ports:
- `rd_clk` in 1: single clock.
- `rd_rst` in 1: asynchronous, active-high reset.
- `drain_en` in 1: when 0, no new FIFO reads are issued; buffered words still drain.
- `fifo_rd_en` out 1: FIFO read enable.
- `fifo_rd_oce` out 1: FIFO output-register enable; constant 1.
- `fifo_rd_data` in `DATA_WIDTH`: FIFO read data.
- `fifo_rd_empty` in 1: FIFO empty flag, valid in the current cycle.
- `m_valid` out 1: stream word valid.
- `m_ready` in 1: consumer ready.
- `m_data` out `DATA_WIDTH`: stream word.
- `busy` out 1: high when any word is in flight or buffered.

## Operation
- **State**
  - `count`: buffered words, 0..`BUF_DEPTH`.
  - `inflight`: reads issued but data not yet returned, 0..`RD_LATENCY`.
  - Circular buffer with `wptr`/`rptr` that wrap modulo `BUF_DEPTH`.
- **Pop**: `pop = m_valid & m_ready`.
- **Issue rule** (combinational): `fifo_rd_en = drain_en & ~fifo_rd_empty & (count + inflight - pop < BUF_DEPTH)`.
  - `fifo_rd_en` is forced to 0 while `rd_rst` is high.
  - Width rule: the sum is computed in `$clog2(BUF_DEPTH+RD_LATENCY)+1` bits, so it never underflows or overflows.
- **Read tracking**: a `RD_LATENCY`-deep shift register of issue flags tracks each read. When a flag exits the shift register, `fifo_rd_data` is written at `wptr`.
- **Output**: `m_valid = (count != 0)`. `m_data` is the buffer entry at `rptr`. `m_data` is held stable while `m_valid & ~m_ready`.
- **Simultaneous events**:
  - Return and pop in the same cycle: `count` is unchanged and both pointers advance.
  - Return into an empty buffer: the word appears on the next cycle; there is no same-cycle bypass.
- **Overflow**: cannot occur by construction. If a return would arrive while `count == BUF_DEPTH`, that is a design error and an assertion fires.
- **drain_en low**: reads already in flight still complete and are buffered.
- **Reset mid-operation**: in-flight reads and buffered words are discarded. Their data is lost; the FIFO is reset in step by the same `rd_rst`.

## Timing
- **Reset values**: `fifo_rd_en`=0, `fifo_rd_oce`=1, `m_valid`=0, `m_data`=0, `busy`=0, `count`=0, `inflight`=0, pointers=0.
- **Latency**: `fifo_rd_en` high in cycle N gives `m_valid` high in cycle N+`RD_LATENCY`+1.
- **Throughput**: with `m_ready` held high and a non-empty FIFO, one word per cycle after the initial latency.
- **Backpressure**: when `m_ready` drops, at most `RD_LATENCY` further words are still accepted from in-flight reads. Reads then stop until a pop occurs.
- **`busy`**: registered; equals `(count!=0)|(inflight!=0)` of the current state.

## Configuration
- **`FIFO_RD_STREAM_WORD_CNT_EN` defined**:
  - Adds output `word_cnt` [31:0], reset value 0.
  - Increments on every pop and wraps from 0xFFFFFFFF to 0.
  - Adds input `word_cnt_clr`; clear takes priority over increment in the same cycle.
- **Macro undefined**: neither port nor the counter logic exists.

## Test plan
- **Basic drain**: FIFO preloaded with 0x11, 0x22, 0x33; `m_ready`=1, `RD_LATENCY`=1 → `m_data` 0x11/0x22/0x33 on three consecutive cycles, first at rd_en cycle+2. Then `m_valid`=0 and `busy`=0.
- **Full throughput**: 64 words, `RD_LATENCY`=2, `m_ready`=1 → 64 consecutive valid cycles, in order, with no gaps after the first.
- **Backpressure**: `m_ready` toggles randomly at 50% over 200 words → every word delivered exactly once and in order; `m_data` stable while stalled; `count` never exceeds `BUF_DEPTH`.
- **Empty boundary**: FIFO holds 1 word, then empty, then 1 more word written 5 cycles later → `fifo_rd_en` never asserted while `fifo_rd_empty`=1; exactly 2 words output.
- **drain_en pause**: `drain_en` dropped with 2 reads in flight → those 2 words still emitted, then no further reads until `drain_en`=1.
- **Reset mid-stream**: `rd_rst` pulsed with `count`=2 → `m_valid`=0 asynchronously; after release, the first word output is the first word written after reset.
